// File: rtl/bm_led_output_stage_if.sv
// Handshake bundle for one BondMachine output port: 8-bit data, valid from the
// processor and the single-cycle received acknowledge back to it.
interface bm_led_output_stage_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_received;

    modport master (
        output in_data,
        output in_valid,
        input  in_received
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_received
    );
endinterface

// File: rtl/bm_led_output_stage.sv
// LED output stage for a BondMachine output port: acknowledges and queues each
// published value, then shows every queued value on the LEDs for a minimum dwell.
module bm_led_output_stage #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int DEDUP       = 1
) (
    input  logic                     clock_signal,
    input  logic                     reset_signal,
    bm_led_output_stage_if.slave     bm_port,
    output logic [7:0]               led,
    output logic                     led_active,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int DWELL_W = $clog2(HOLD_CYCLES) + 1;

    localparam logic [LVL_W-1:0]   LEVEL_FULL = LVL_W'(DEPTH);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           fifo_mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   dwell_d;
    logic [7:0]           led_d;
    logic                 led_active_d;
    logic                 received_q;
    logic [7:0]           last_data;
    logic                 last_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 is_dup;
    logic                 accept;
    logic                 push;
    logic                 pop;

    assign fifo_full  = (fifo_level == LEVEL_FULL);
    assign fifo_empty = (fifo_level == '0);

    // Received blocks a second capture: the processor still holds valid on
    // the edge where it first sees the acknowledge.
    assign is_dup = (DEDUP != 0) && last_valid && (bm_port.in_data == last_data);
    assign accept = bm_port.in_valid && !received_q && !fifo_full;
    assign push   = accept && !is_dup;

    assign bm_port.in_received = received_q;

    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            received_q <= 1'b0;
            last_data  <= 8'h00;
            last_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            received_q <= accept;
            if (accept) begin
                last_data  <= bm_port.in_data;
                last_valid <= 1'b1;
            end
            if (bm_port.in_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the pointers and level define what is valid.
    always_ff @(posedge clock_signal) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bm_port.in_data;
        end
    end

    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            state_q    <= IDLE;
            dwell_q    <= '0;
            led        <= 8'h00;
            led_active <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            led        <= led_d;
            led_active <= led_active_d;
        end
    end

    // Pops only see the level from before the edge, so a value pushed on this
    // edge is never shown until the following one.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        led_d        = led;
        led_active_d = led_active;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    led_d        = fifo_mem[rd_ptr];
                    dwell_d      = DWELL_LOAD;
                    led_active_d = 1'b1;
                    state_d      = SHOW;
                end
            end
            SHOW: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (!fifo_empty) begin
                    pop          = 1'b1;
                    led_d        = fifo_mem[rd_ptr];
                    dwell_d      = DWELL_LOAD;
                    led_active_d = 1'b1;
                end else begin
                    led_active_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                led_active_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/bm_led_output_stage.md
Name: bm_led_output_stage

Overview:
Downstream consumer of one BondMachine output port (8-bit data plus valid/received handshake). It accepts each value the processor publishes and queues it in a small FIFO. It then shows each queued value on the board LEDs for a fixed minimum dwell time, so that short-lived R2O updates stay visible. It replaces the per-bit LED register stage between the bondmachine core and the board pins.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2.
HOLD_CYCLES, 50000000, minimum clock cycles each value is shown on led; >=1.
DEDUP, 1, when 1, a value equal to the last accepted value is acknowledged but not enqueued.

Ports:
clock_signal  input  1  system clock, all state on rising edge.
reset_signal  input  1  asynchronous, active-low reset.
in_data  input  8  output-port data from processor (o0).
in_valid  input  1  output-port valid from processor (o0_valid).
in_received  output  1  registered acknowledge to processor (o0_received); one-cycle pulse per accepted value.
led  output  8  registered LED drive.
led_active  output  1  high while the dwell counter is running (state SHOW).
fifo_level  output  $clog2(DEPTH)+1  current number of queued entries.
overflow  output  1  sticky; set when in_valid is held high while full, cleared only by reset.

Behaviour:
- Reset (reset_signal=0, async): in_received=0, led=8'h00, led_active=0, fifo_level=0, overflow=0, state=IDLE, dwell=0, last_accepted invalid (no dedup match possible).
- Accept rule, evaluated at each edge: accept = in_valid & ~in_received & (fifo_level<DEPTH).
  - in_received is blocked because the processor clears valid on the edge after seeing received. This prevents a double capture of the same value.
- On accept: in_received<=1 for exactly one cycle and last_accepted<=in_data.
  - The value is enqueued unless DEDUP=1 and in_data==last_accepted (in that case acknowledge only).
- When not accepting, in_received<=0.
- Full: no acknowledge, so the processor keeps valid high (backpressure). If in_valid=1 and the FIFO is full at an edge, overflow<=1.
- FIFO: circular, read/write pointers wrap modulo DEPTH, level tracked separately. A push and a pop on the same edge leave the level unchanged.
  - Push requires level<DEPTH sampled before the edge; there is no pass-through when full.
- State machine:
  - IDLE, level>0: pop the head; led<=head, dwell<=HOLD_CYCLES-1, led_active<=1, go to SHOW.
  - IDLE, level==0: hold led unchanged. The last value stays lit indefinitely.
  - SHOW, dwell>0: dwell<=dwell-1.
  - SHOW, dwell==0 and level>0: pop the next value back-to-back; led<=head, dwell reloaded, stay in SHOW.
  - SHOW, dwell==0 and level==0: go to IDLE, led_active<=0, led held.
- Each value is on led for exactly HOLD_CYCLES cycles while a successor is queued, and at least HOLD_CYCLES cycles otherwise.
- Latency: valid seen before edge E0 → capture at E0, in_received high E0..E1 → if IDLE, led updated at E1 (2 edges after valid).
- Dwell counter width is $clog2(HOLD_CYCLES)+1 bits. There is no wrap; it saturates at 0.
- Reset asserted mid-SHOW or mid-handshake: immediate return to reset values; queued data is discarded. The processor's pending valid is re-acknowledged after reset release.
- in_data is sampled only on accepting edges; it is ignored otherwise.

Test Plan:
- Reset release, in_valid=0 for 20 cycles → led=00, led_active=0, in_received never high, fifo_level=0.
- HOLD_CYCLES=4: in_valid=1 with 8'h5A, dropped after in_received → in_received is a single-cycle pulse, led=5A two edges after valid, led_active high exactly 4 cycles, then led stays 5A.
- HOLD_CYCLES=4, DEDUP=0: push 01,02,03 back-to-back → each shown exactly 4 cycles in order, with no gaps in led_active.
- DEPTH=4, HOLD_CYCLES=100: push 10,11,12,13,14,15 → 10 is popped to led, 11–14 fill the FIFO (level=4), 15 is held without acknowledgement and overflow=1. 15 is accepted when 11 pops at dwell end.
- DEDUP=1: push 07, 07, 08 → both 07s acknowledged, only 07 and 08 displayed, peak fifo_level=1.
- Assert reset_signal=0 mid-SHOW with 3 queued → led=00, fifo_level=0, overflow=0 asynchronously, before the next clock edge.
